// File: rtl/x_multdiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// x_multdiv_unit_pkg
// Shared pipeline definitions for the execute-stage multiply/divide unit:
//   - XLEN              : operand/result width
//   - ST_*              : FSM state encoding
//   - MODE_*            : iteration-step mode select
//   - MULTDIV_EXC_CODE  : cause code the W stage writes to the status
//                         register when out_exception accompanies a result
// -----------------------------------------------------------------------------
package x_multdiv_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_MULT = 1'b0;
    localparam logic MODE_DIV  = 1'b1;

    localparam logic [3:0] MULTDIV_EXC_CODE = 4'd12;

endpackage

// File: rtl/x_multdiv_unit_md_iter_step.sv
// -----------------------------------------------------------------------------
// x_multdiv_unit_md_iter_step
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   mode_i  : MODE_MULT = radix-2 Booth step, MODE_DIV = restoring step
//   acc_i   : 2W+1 bit working register
//             mult: {product_hi[W-1:0], product_lo[W-1:0], booth_bit}
//             div : {remainder[W:0], quotient/dividend[W-1:0]}
//   opnd_i  : multiplicand (signed) or divisor magnitude (unsigned)
//   acc_o   : working register after this iteration
// -----------------------------------------------------------------------------
module x_multdiv_unit_md_iter_step
    import x_multdiv_unit_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic           mode_i,
    input  logic [2*W:0]   acc_i,
    input  logic [W-1:0]   opnd_i,
    output logic [2*W:0]   acc_o
);

    logic [W:0]   hi_ext_s;
    logic [W:0]   op_ext_s;
    logic [W:0]   booth_sum_s;
    logic [2*W:0] shl_s;
    logic [W:0]   trial_s;

    // Booth add/sub and restoring trial subtract, then select by mode
    always_comb begin
        // One guard bit on the Booth adder keeps the most-negative
        // multiplicand exact; the shift drops the guard again.
        hi_ext_s    = {acc_i[2*W], acc_i[2*W:W+1]};
        op_ext_s    = {opnd_i[W-1], opnd_i};
        booth_sum_s = hi_ext_s;
        case (acc_i[1:0])
            2'b01:   booth_sum_s = hi_ext_s + op_ext_s;
            2'b10:   booth_sum_s = hi_ext_s - op_ext_s;
            default: booth_sum_s = hi_ext_s;
        endcase

        // Remainder stays below the divisor, so the shifted remainder fits
        // W+1 bits and bit W of the trial flags a borrow.
        shl_s   = {acc_i[2*W-1:0], 1'b0};
        trial_s = shl_s[2*W:W] - {1'b0, opnd_i};

        if (mode_i == MODE_MULT) begin
            acc_o = {booth_sum_s, acc_i[W:1]};
        end else if (trial_s[W] == 1'b0) begin
            acc_o = {trial_s, shl_s[W-1:1], 1'b1};
        end else begin
            acc_o = shl_s;
        end
    end

endmodule

// File: rtl/x_multdiv_unit.sv
// -----------------------------------------------------------------------------
// x_multdiv_unit
// Iterative signed multiply / divide for the X stage. One bit per cycle,
// 32 iterations, result bundle presented for one cycle in DONE.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_start_mult/_div      : single-cycle start pulses (mult wins if both)
//   in_operandA/B           : multiplicand/dividend, multiplier/divisor
//   in_rd                   : destination register of the issuing instruction
//   in_flush                : synchronous abort, no result is produced
//   out_stall               : combinational hold for PC, F/D and D/X
//   out_result_ready        : one-cycle result-valid pulse
//   out_result/_exception/_rd : registered bundle, valid with ready
// -----------------------------------------------------------------------------
module x_multdiv_unit
    import x_multdiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_start_mult,
    input  logic                  in_start_div,
    input  logic [DATA_WIDTH-1:0] in_operandA,
    input  logic [DATA_WIDTH-1:0] in_operandB,
    input  logic [4:0]            in_rd,
    input  logic                  in_flush,
    output logic                  out_stall,
    output logic                  out_result_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_exception,
    output logic [4:0]            out_rd
);

    localparam int AW = 2 * DATA_WIDTH + 1;

    logic [1:0]            state_q,  state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [AW-1:0]         acc_q,    acc_d;
    logic [DATA_WIDTH-1:0] opnd_q,   opnd_d;
    logic                  neg_q,    neg_d;
    logic [4:0]            rd_cap_q, rd_cap_d;
    logic                  ready_q,  ready_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  exc_q,    exc_d;
    logic [4:0]            rd_out_q, rd_out_d;

    logic                  step_mode_s;
    logic [AW-1:0]         step_acc_s;
    logic [DATA_WIDTH-1:0] abs_a_s;
    logic [DATA_WIDTH-1:0] abs_b_s;
    logic [DATA_WIDTH-1:0] quot_mag_s;
    logic [DATA_WIDTH-1:0] quot_s;
    logic                  mul_ovf_s;
    logic                  last_s;

    assign step_mode_s = (state_q == ST_DIV) ? MODE_DIV : MODE_MULT;

    x_multdiv_unit_md_iter_step #(
        .W (DATA_WIDTH)
    ) u_step (
        .mode_i (step_mode_s),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc_s)
    );

    // Magnitudes wrap for the most negative value; 0x80000000 is then read
    // as the unsigned magnitude 2^31, which the divider handles directly.
    assign abs_a_s = in_operandA[DATA_WIDTH-1] ? (~in_operandA + DATA_WIDTH'(1)) : in_operandA;
    assign abs_b_s = in_operandB[DATA_WIDTH-1] ? (~in_operandB + DATA_WIDTH'(1)) : in_operandB;

    assign quot_mag_s = step_acc_s[DATA_WIDTH-1:0];
    assign quot_s     = neg_q ? (~quot_mag_s + DATA_WIDTH'(1)) : quot_mag_s;
    assign mul_ovf_s  = (step_acc_s[AW-1:DATA_WIDTH+1] != {DATA_WIDTH{step_acc_s[DATA_WIDTH]}});
    assign last_s     = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    // Stall holds upstream while a start is accepted or iterating; flush or
    // reset drops it immediately so the front end can redirect.
    assign out_stall = ~reset & ~in_flush &
                       (((state_q == ST_IDLE) & (in_start_mult | in_start_div)) |
                        (state_q == ST_MULT) | (state_q == ST_DIV));

    // Next-state logic for FSM, counter, datapath and result bundle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rd_cap_d = rd_cap_q;
        ready_d  = 1'b0;
        result_d = result_q;
        exc_d    = exc_q;
        rd_out_d = rd_out_q;

        if (in_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_start_mult) begin
                        state_d  = ST_MULT;
                        cnt_d    = '0;
                        acc_d    = {{DATA_WIDTH{1'b0}}, in_operandB, 1'b0};
                        opnd_d   = in_operandA;
                        rd_cap_d = in_rd;
                    end else if (in_start_div) begin
                        if (in_operandB == '0) begin
                            // Divide-by-zero is known up front: skip iterating
                            state_d  = ST_DONE;
                            ready_d  = 1'b1;
                            result_d = '0;
                            exc_d    = 1'b1;
                            rd_out_d = in_rd;
                        end else begin
                            state_d  = ST_DIV;
                            cnt_d    = '0;
                            acc_d    = {{(DATA_WIDTH + 1){1'b0}}, abs_a_s};
                            opnd_d   = abs_b_s;
                            neg_d    = in_operandA[DATA_WIDTH-1] ^ in_operandB[DATA_WIDTH-1];
                            rd_cap_d = in_rd;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MULT: begin
                    acc_d = step_acc_s;
                    if (last_s) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        result_d = step_acc_s[DATA_WIDTH:1];
                        exc_d    = mul_ovf_s;
                        rd_out_d = rd_cap_q;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_DIV: begin
                    acc_d = step_acc_s;
                    if (last_s) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        result_d = quot_s;
                        // A positive quotient with the top bit set can only
                        // come from 0x80000000 / -1.
                        exc_d    = ~neg_q & quot_mag_s[DATA_WIDTH-1];
                        rd_out_d = rd_cap_q;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rd_cap_q <= 5'd0;
            ready_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rd_cap_q <= rd_cap_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign out_result_ready = ready_q;
    assign out_result       = result_q;
    assign out_exception    = exc_q;
    assign out_rd           = rd_out_q;

endmodule

// File: doc/x_multdiv_unit.md
Name: x_multdiv_unit

Overview:
- Iterative signed multiply/divide unit in the execute (X) stage, directly upstream of the X/M pipeline latch.
- Accepts a start pulse with two 32-bit operands and the destination register.
- Holds the pipeline with a stall while it iterates.
- Presents a one-cycle result/exception/rd bundle that the X stage writes into the X/M latch in place of the ALU result.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CNT_WIDTH, 6, iteration counter width (must hold DATA_WIDTH)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_start_mult  in  1  start signed multiply (single-cycle pulse)
- in_start_div  in  1  start signed divide (single-cycle pulse)
- in_operandA  in  32  multiplicand / dividend
- in_operandB  in  32  multiplier / divisor
- in_rd  in  5  destination register of the issuing instruction
- in_flush  in  1  synchronous abort (branch taken downstream)
- out_stall  out  1  freeze PC, F/D and D/X latches
- out_result_ready  out  1  one-cycle pulse: result valid
- out_result  out  32  product low word / quotient
- out_exception  out  1  overflow or divide-by-zero, valid with ready
- out_rd  out  5  captured rd, valid with ready

Behaviour:
- Reset is synchronous: on a clock edge with reset=1 the block returns to IDLE.
  - Counter and all registers clear to 0.
  - out_stall=0, out_result_ready=0, out_result=0, out_exception=0, out_rd=0.
- States:
  - IDLE: waiting for a start pulse.
  - MULT: radix-2 Booth, 1 bit per cycle.
  - DIV: restoring divide on magnitudes, 1 bit per cycle.
  - DONE: one cycle, result presented.
- IDLE -> MULT on in_start_mult. Capture A, B, rd; load product register {32'b0, B, 1'b0}; counter=0.
- IDLE -> DIV on in_start_div with B != 0.
  - Capture |A|, |B|, sign flags and rd; counter=0.
- IDLE -> DONE on in_start_div with B == 0 (divide-by-zero fast path): result=0, exception=1.
- If start_mult and start_div are both high, multiply wins; the divide request is dropped.
- MULT/DIV -> DONE when the counter reaches DATA_WIDTH-1. Exactly 32 iterations.
- DONE -> IDLE unconditionally.
- Latency: start in cycle 0; iterations in cycles 1..32; out_result_ready=1 in cycle 33. Divide-by-zero is ready in cycle 1.
- out_stall is combinational:
  - high when (IDLE and any start) or state is MULT or DIV;
  - low in DONE, so the X stage advances and the X/M latch captures the result in that cycle.
- Outputs out_result, out_exception and out_rd are registered.
  - They are valid only while out_result_ready=1.
  - They hold their last value otherwise.
- Multiply:
  - Booth on the 65-bit product register with an arithmetic shift right per step.
  - out_result = product[31:0].
  - out_exception = 1 when product[63:32] is not all copies of product[31] (signed 32-bit overflow).
- Divide:
  - Truncates toward zero.
  - Quotient is negated if sign(A) XOR sign(B). The remainder is discarded.
  - 0x80000000 / -1: result 0x80000000, exception=1.
- Start pulses arriving in MULT, DIV or DONE are ignored (no queueing). The decode stage relies on the stall to prevent them.
- in_flush has priority over normal transitions but not over reset.
  - Any state returns to IDLE next edge.
  - No out_result_ready pulse is produced.
  - out_stall drops the same cycle as flush is sampled in MULT/DIV.
  - A start coincident with flush is ignored.
- Reset mid-operation behaves like flush plus clearing all outputs.
- All arithmetic is two's complement. Negation of the magnitude uses ~x+1, with no saturation.

Decomposition:
- Shared package (pipeline pkg) holds:
  - state encoding: IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3;
  - DATA_WIDTH;
  - the exception code the W stage writes to the status register for multdiv.
- One natural sub-module, md_iter_step: a combinational single iteration.
  - Booth add/sub plus arithmetic shift, or restoring subtract plus shift, selected by mode.
  - The top level keeps the FSM, counter and registers.

Test Plan:
- A=7, B=-3, start_mult at cycle 0: stall=1 for cycles 0..32; cycle 33 gives ready=1, result=0xFFFFFFEB, exception=0, out_rd = captured rd.
- A=0x00010000, B=0x00010000, start_mult: cycle 33 gives result=0x00000000, exception=1. Also A=0x80000000, B=1: result=0x80000000, exception=0.
- A=-100, B=7, start_div: cycle 33 gives result=0xFFFFFFF2 (-14), exception=0. Also A=100, B=0: cycle 1 gives ready=1, result=0, exception=1, stall low in cycle 1.
- A=0x80000000, B=-1, start_div: cycle 33 gives result=0x80000000, exception=1.
- start_mult at cycle 0, flush at cycle 10: stall=0 from cycle 10; no ready pulse in cycles 10..40. A fresh start at cycle 12 completes at cycle 45.
- Reset asserted at cycle 5 of a divide: all outputs 0 from cycle 6. start_mult and start_div together at cycle 8 run a multiply, with ready at cycle 41.
